// File: rtl/reg_ctrl.sv
// ---------------------------------------------------------------------------
// reg_ctrl
//
// Byte-stream command front end for the gate-time register file. Host bytes
// arrive on a valid/ready rx link. A CMD_WR opcode is followed by 8 payload
// bytes that are assembled (byte 0 in bits 7:0) into one 64-bit word and
// strobed into the register file. A CMD_RD opcode freezes the register-file
// snapshot and streams byte addresses 0..RD_BYTES-1 back on the tx link.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   rx_data_i      host command/payload byte
//   rx_valid_i     rx byte valid
//   rx_ready_o     block can accept an rx byte (IDLE / WR_DATA only)
//   tx_data_o      readout byte to host (8'h00 while tx_valid_o is low)
//   tx_valid_o     tx byte valid
//   tx_ready_i     host accepts tx byte
//   reg_wr_en_o    one-cycle write strobe to register file
//   reg_wr_data_o  assembled write word
//   reg_rd_en_o    high while the register-file snapshot is frozen
//   reg_rd_addr_o  register-file byte address being read out
//   reg_rd_data_i  register-file byte at reg_rd_addr_o (same-cycle)
//   busy_o         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module reg_ctrl #(
  parameter logic [7:0] CMD_WR   = 8'h2A,
  parameter logic [7:0] CMD_RD   = 8'h3A,
  parameter int         RD_BYTES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        reg_wr_en_o,
  output logic [63:0] reg_wr_data_o,
  output logic        reg_rd_en_o,
  output logic [3:0]  reg_rd_addr_o,
  input  logic [7:0]  reg_rd_data_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_COMMIT,
    RD_SNAP,
    RD_SEND
  } state_e;

  localparam logic [3:0] LAST_ADDR = 4'(RD_BYTES - 1);

  state_e      state_q, state_d;
  logic [2:0]  wrCnt_q, wrCnt_d;
  logic [63:0] wrData_q, wrData_d;
  logic [3:0]  rdAddr_q, rdAddr_d;

  logic rxHs;
  logic txHs;

  // State and datapath registers; reset discards any partial write and
  // aborts a readout in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wrCnt_q  <= 3'd0;
      wrData_q <= 64'd0;
      rdAddr_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      wrCnt_q  <= wrCnt_d;
      wrData_q <= wrData_d;
      rdAddr_q <= rdAddr_d;
    end
  end

  // rx_ready is forced low during reset so no byte is consumed by a
  // handshake the FSM is about to forget.
  assign rx_ready_o = ~rst_i & ((state_q == IDLE) | (state_q == WR_DATA));
  assign rxHs       = rx_valid_i & rx_ready_o;
  assign txHs       = tx_valid_o & tx_ready_i;

  // Next-state logic. Payload bytes land in the lane chosen by wrCnt; the
  // other lanes keep their previous contents until overwritten.
  always_comb begin
    state_d  = state_q;
    wrCnt_d  = wrCnt_q;
    wrData_d = wrData_q;
    rdAddr_d = rdAddr_q;

    unique case (state_q)
      IDLE: begin
        if (rxHs) begin
          if (rx_data_i == CMD_WR) begin
            wrCnt_d = 3'd0;
            state_d = WR_DATA;
          end else if (rx_data_i == CMD_RD) begin
            state_d = RD_SNAP;
          end
        end
      end

      WR_DATA: begin
        if (rxHs) begin
          wrData_d[{wrCnt_q, 3'b000} +: 8] = rx_data_i;
          wrCnt_d = wrCnt_q + 3'd1;
          if (wrCnt_q == 3'd7) begin
            state_d = WR_COMMIT;
          end
        end
      end

      WR_COMMIT: begin
        state_d = IDLE;
      end

      // reg_rd_en is still low here so the register file refreshes its
      // readback copy with the most recent write before the freeze.
      RD_SNAP: begin
        rdAddr_d = 4'd0;
        state_d  = RD_SEND;
      end

      RD_SEND: begin
        if (txHs) begin
          if (rdAddr_q == LAST_ADDR) begin
            rdAddr_d = 4'd0;
            state_d  = IDLE;
          end else begin
            rdAddr_d = rdAddr_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign reg_wr_en_o   = (state_q == WR_COMMIT);
  assign reg_wr_data_o = wrData_q;
  assign reg_rd_en_o   = (state_q == RD_SEND);
  assign reg_rd_addr_o = rdAddr_q;
  assign tx_valid_o    = (state_q == RD_SEND);
  assign tx_data_o     = tx_valid_o ? reg_rd_data_i : 8'h00;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_ctrl
//
// Self-checking bench for reg_ctrl. A small register-file model supplies the
// readback bytes: bytes 0..7 are fixed gate-time defaults, bytes 8..15 are
// the last committed word, and the readback copy only refreshes while
// reg_rd_en_o is low. Expected data comes from the bench's own record of
// which payload bytes were sent. A second instance with RD_BYTES=4 covers
// the short-readout build.
// ---------------------------------------------------------------------------
module tb_reg_ctrl;

  localparam logic [7:0] CMD_WR = 8'h2A;
  localparam logic [7:0] CMD_RD = 8'h3A;
  localparam int         NBYTES = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        reg_wr_en_o;
  logic [63:0] reg_wr_data_o;
  logic        reg_rd_en_o;
  logic [3:0]  reg_rd_addr_o;
  logic [7:0]  reg_rd_data_i;
  logic        busy_o;

  logic [7:0]  rx4Data = 8'h00;
  logic        rx4Valid = 1'b0;
  logic        rx4Ready;
  logic [7:0]  tx4Data;
  logic        tx4Valid;
  logic        tx4Ready = 1'b1;
  logic        wr4En;
  logic [63:0] wr4Data;
  logic        rd4En;
  logic [3:0]  rd4Addr;
  logic [7:0]  rd4Data;
  logic        busy4;

  int total = 0;
  int bad   = 0;

  logic [63:0] defWord   = 64'hC7C6C5C4C3C2C1C0;
  logic [63:0] latest    = 64'd0;
  logic [7:0]  snap [16];
  logic [63:0] expWord   = 64'd0;
  int          wrPulses  = 0;

  logic [7:0]  capBytes[$];
  logic [3:0]  capAddrs[$];
  int latency, stallChanges, rxReadyHigh, rdEnLow, dataWhileIdle, timedOut, rxTimeouts;
  bit pat6 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk_i = ~clk_i;

  reg_ctrl #(.CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .RD_BYTES(NBYTES)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_wr_data_o(reg_wr_data_o),
    .reg_rd_en_o(reg_rd_en_o), .reg_rd_addr_o(reg_rd_addr_o),
    .reg_rd_data_i(reg_rd_data_i), .busy_o(busy_o)
  );

  reg_ctrl #(.CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .RD_BYTES(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx4Data), .rx_valid_i(rx4Valid), .rx_ready_o(rx4Ready),
    .tx_data_o(tx4Data), .tx_valid_o(tx4Valid), .tx_ready_i(tx4Ready),
    .reg_wr_en_o(wr4En), .reg_wr_data_o(wr4Data),
    .reg_rd_en_o(rd4En), .reg_rd_addr_o(rd4Addr),
    .reg_rd_data_i(rd4Data), .busy_o(busy4)
  );

  // Register-file model: commit latches the word, readback copy refreshes
  // whenever the snapshot is not frozen.
  always @(posedge clk_i) begin
    if (reg_wr_en_o) latest <= reg_wr_data_o;
    if (!reg_rd_en_o) begin
      for (int i = 0; i < 16; i++)
        snap[i] <= (i < 8) ? defWord[8*i +: 8] : latest[8*(i-8) +: 8];
    end
    if (reg_wr_en_o) wrPulses = wrPulses + 1;
  end

  assign reg_rd_data_i = snap[reg_rd_addr_o];
  assign rd4Data       = {4'hA, rd4Addr};

  function automatic logic [7:0] exp_byte(input int a);
    logic [63:0] d;
    logic [63:0] w;
    d = 64'hC7C6C5C4C3C2C1C0;
    w = expWord;
    return (a < 8) ? d[8*a +: 8] : w[8*(a-8) +: 8];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one byte and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 20 && !rx_ready_o; i++) tick();
    if (!rx_ready_o) rxTimeouts++;
    tick();
    rx_valid_i = 1'b0;
  endtask

  // Issue CMD_RD and collect the readout under the chosen tx_ready pattern
  // (0 = always ready, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random).
  task automatic run_read(input int mode);
    int cyc;
    int patIdx;
    logic [7:0] heldData;
    logic [3:0] heldAddr;
    bit stalled;
    capBytes.delete();
    capAddrs.delete();
    latency = 0; stallChanges = 0; rxReadyHigh = 0; rdEnLow = 0;
    dataWhileIdle = 0; timedOut = 0;
    heldData = 8'h00; heldAddr = 4'h0;
    tx_ready_i = 1'b0;
    rx_data_i  = CMD_RD;
    rx_valid_i = 1'b1;
    #1;
    if (!rx_ready_o) begin
      timedOut = 1;
      rx_valid_i = 1'b0;
      return;
    end
    tick();
    rx_valid_i = 1'b0;
    latency = 1;
    while (!tx_valid_o && latency < 10) begin
      if (tx_data_o !== 8'h00) dataWhileIdle++;
      if (rx_ready_o) rxReadyHigh++;
      tick();
      latency++;
    end
    stalled = 0; patIdx = 0; cyc = 0;
    while (capBytes.size() < NBYTES && cyc < 400) begin
      if (stalled && (tx_data_o !== heldData || reg_rd_addr_o !== heldAddr || tx_valid_o !== 1'b1))
        stallChanges++;
      case (mode)
        0:       tx_ready_i = 1'b1;
        1:       begin tx_ready_i = pat6[patIdx % 6]; patIdx++; end
        default: tx_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rx_ready_o) rxReadyHigh++;
      if (!reg_rd_en_o) rdEnLow++;
      stalled = 0;
      if (tx_valid_o && tx_ready_i) begin
        capBytes.push_back(tx_data_o);
        capAddrs.push_back(reg_rd_addr_o);
      end else if (tx_valid_o) begin
        stalled  = 1;
        heldData = tx_data_o;
        heldAddr = reg_rd_addr_o;
      end
      tick();
      cyc++;
    end
    tx_ready_i = 1'b0;
    if (cyc >= 400) timedOut = 1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1;
    total++; if (rx_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_rx_ready_async: got %b want 0", rx_ready_o); end
    repeat (3) tick();
    total++; if ({busy_o, tx_valid_o, reg_rd_en_o, reg_wr_en_o} !== 4'b0000) begin bad++; $display("[TB] FAIL rst_flags: got %b want 0000", {busy_o, tx_valid_o, reg_rd_en_o, reg_wr_en_o}); end
    total++; if (reg_wr_data_o !== 64'd0 || reg_rd_addr_o !== 4'd0 || tx_data_o !== 8'h00) begin bad++; $display("[TB] FAIL rst_data: got %h/%h/%h want 0", reg_wr_data_o, reg_rd_addr_o, tx_data_o); end
    rst_i = 1'b0;
    #1;
    total++; if (rx_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %b want 1", rx_ready_o); end

    // Start a readout and reset in the middle of it.
    rx_data_i = CMD_RD; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (4) tick();
    total++; if (tx_valid_o !== 1'b1 || reg_rd_addr_o === 4'd0) begin bad++; $display("[TB] FAIL rst_midread_setup: got valid=%b addr=%0d want valid=1 addr>0", tx_valid_o, reg_rd_addr_o); end
    rst_i = 1'b1;
    #1;
    total++; if (rx_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_rx_ready: got %b want 0", rx_ready_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({busy_o, tx_valid_o, reg_rd_en_o, rx_ready_o} !== 4'b0000 || reg_rd_addr_o !== 4'd0 || tx_data_o !== 8'h00) begin
        bad++; $display("[TB] FAIL rst_mid_cycle%0d: got busy=%b txv=%b rden=%b rdy=%b addr=%0d tx=%h want all 0", c, busy_o, tx_valid_o, reg_rd_en_o, rx_ready_o, reg_rd_addr_o, tx_data_o);
      end
    end
    tx_ready_i = 1'b0;
    rst_i = 1'b0;
    #1;
    total++; if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_release: got rdy=%b busy=%b want 1/0", rx_ready_o, busy_o); end
    tick();
  endtask

  task automatic test_write();
    logic [7:0] seq [9];
    int p0;
    seq = '{8'h2A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    p0 = wrPulses;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(seq[i]);
      if (i < 8) begin
        total++; if (reg_wr_en_o !== 1'b0) begin bad++; $display("[TB] FAIL write_early_strobe byte%0d: got %b want 0", i, reg_wr_en_o); end
      end
    end
    expWord = 64'h0807060504030201;
    total++; if (reg_wr_en_o !== 1'b1) begin bad++; $display("[TB] FAIL write_strobe: got %b want 1", reg_wr_en_o); end
    total++; if (reg_wr_data_o !== expWord) begin bad++; $display("[TB] FAIL write_word: got %h want %h", reg_wr_data_o, expWord); end
    tick();
    total++; if (reg_wr_en_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL write_after: got en=%b busy=%b want 0/0", reg_wr_en_o, busy_o); end
    total++; if (wrPulses - p0 !== 1) begin bad++; $display("[TB] FAIL write_pulse_count: got %0d want 1", wrPulses - p0); end
    total++; if (reg_wr_data_o !== expWord) begin bad++; $display("[TB] FAIL write_hold: got %h want %h", reg_wr_data_o, expWord); end
  endtask

  task automatic check_read(input string tag, input int wantLat);
    total++; if (timedOut !== 0) begin bad++; $display("[TB] FAIL %s_timeout: got %0d want 0", tag, timedOut); end
    if (wantLat > 0) begin
      total++; if (latency !== wantLat) begin bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", tag, latency, wantLat); end
    end
    total++; if (capBytes.size() !== NBYTES) begin bad++; $display("[TB] FAIL %s_count: got %0d want %0d", tag, capBytes.size(), NBYTES); end
    for (int i = 0; i < capBytes.size(); i++) begin
      total++; if (capAddrs[i] !== 4'(i) || capBytes[i] !== exp_byte(i)) begin
        bad++; $display("[TB] FAIL %s_byte%0d: got addr=%0d data=%h want addr=%0d data=%h", tag, i, capAddrs[i], capBytes[i], i, exp_byte(i));
      end
    end
    total++; if (rxReadyHigh !== 0 || rdEnLow !== 0 || stallChanges !== 0 || dataWhileIdle !== 0) begin
      bad++; $display("[TB] FAIL %s_during: got rdyHigh=%0d rdEnLow=%0d stallChg=%0d idleData=%0d want 0", tag, rxReadyHigh, rdEnLow, stallChanges, dataWhileIdle);
    end
    total++; if ({tx_valid_o, reg_rd_en_o, busy_o} !== 3'b000 || reg_rd_addr_o !== 4'd0 || tx_data_o !== 8'h00) begin
      bad++; $display("[TB] FAIL %s_end: got txv=%b rden=%b busy=%b addr=%0d tx=%h want 0", tag, tx_valid_o, reg_rd_en_o, busy_o, reg_rd_addr_o, tx_data_o);
    end
  endtask

  task automatic test_read_after_write();
    run_read(0);
    check_read("raw", 2);
  endtask

  task automatic test_backpressure();
    run_read(1);
    check_read("bp", 0);
  endtask

  task automatic test_abort_junk();
    int p0;
    logic [63:0] w;
    applyStimulus(8'h55);
    total++; if (busy_o !== 1'b0 || rx_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL junk_dropped: got busy=%b rdy=%b want 0/1", busy_o, rx_ready_o); end
    p0 = wrPulses;
    applyStimulus(CMD_WR);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    total++; if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_partial_busy: got %b want 1", busy_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    total++; if (wrPulses !== p0) begin bad++; $display("[TB] FAIL abort_no_strobe: got %0d pulses want 0", wrPulses - p0); end
    total++; if (reg_wr_data_o !== 64'd0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_cleared: got %h busy=%b want 0", reg_wr_data_o, busy_o); end
    applyStimulus(CMD_WR);
    w = 64'd0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      w[8*i +: 8] = b;
      applyStimulus(b);
    end
    expWord = w;
    total++; if (reg_wr_en_o !== 1'b1 || reg_wr_data_o !== w) begin bad++; $display("[TB] FAIL abort_clean_word: got en=%b %h want 1 %h", reg_wr_en_o, reg_wr_data_o, w); end
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [63:0] w;
      logic [7:0] junk;
      int p0;
      junk = 8'($urandom);
      if (junk == CMD_WR || junk == CMD_RD) junk = 8'h00;
      applyStimulus(junk);
      total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_junk: got busy=%b want 0", it, busy_o); end
      p0 = wrPulses;
      applyStimulus(CMD_WR);
      w = 64'd0;
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        w[8*i +: 8] = b;
        repeat ($urandom_range(0, 2)) tick();
        applyStimulus(b);
      end
      expWord = w;
      total++; if (reg_wr_en_o !== 1'b1 || reg_wr_data_o !== w) begin bad++; $display("[TB] FAIL rnd%0d_word: got en=%b %h want 1 %h", it, reg_wr_en_o, reg_wr_data_o, w); end
      repeat (1 + $urandom_range(0, 2)) tick();
      total++; if (wrPulses - p0 !== 1) begin bad++; $display("[TB] FAIL rnd%0d_pulses: got %0d want 1", it, wrPulses - p0); end
      run_read(2);
      check_read($sformatf("rnd%0d", it), 2);
    end
  endtask

  task automatic test_param();
    int hs;
    int wrongAddr;
    hs = 0; wrongAddr = 0;
    rx4Data = CMD_RD; rx4Valid = 1'b1;
    #1;
    total++; if (rx4Ready !== 1'b1) begin bad++; $display("[TB] FAIL p4_ready: got %b want 1", rx4Ready); end
    tick();
    rx4Valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (tx4Valid && tx4Ready) begin
        if (rd4Addr !== 4'(hs) || tx4Data !== {4'hA, 4'(hs)}) wrongAddr++;
        hs++;
      end
      tick();
    end
    total++; if (hs !== 4) begin bad++; $display("[TB] FAIL p4_count: got %0d want 4", hs); end
    total++; if (wrongAddr !== 0) begin bad++; $display("[TB] FAIL p4_order: got %0d bad bytes want 0", wrongAddr); end
    total++; if ({tx4Valid, rd4En, busy4, wr4En} !== 4'b0000 || rd4Addr !== 4'd0 || wr4Data !== 64'd0) begin
      bad++; $display("[TB] FAIL p4_end: got txv=%b rden=%b busy=%b wren=%b addr=%0d wd=%h want 0", tx4Valid, rd4En, busy4, wr4En, rd4Addr, wr4Data);
    end
  endtask

  initial begin
    rxTimeouts = 0;
    for (int i = 0; i < 16; i++) snap[i] = 8'h00;
    #2;
    test_reset();
    test_write();
    test_read_after_write();
    test_backpressure();
    test_abort_junk();
    test_random();
    test_param();
    total++; if (rxTimeouts !== 0) begin bad++; $display("[TB] FAIL rx_accept_timeouts: got %0d want 0", rxTimeouts); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
